// File: rtl/core_sequencer_if.sv
// Control bus between the sequencer and the RV32I datapath.
//   opcode/funct3  : instruction fields from the IR (datapath -> sequencer)
//   branch_taken   : ALU compare result, meaningful in EXEC
//   ir_we, pc_we, rf_we, mem_read_en, mem_write_en : datapath write strobes
//   pc_sel, wb_sel : mux selects that qualify pc_we / rf_we
interface core_sequencer_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       mem_read_en;
  logic       mem_write_en;

  // Sequencer side
  modport master (
    input  opcode, funct3, branch_taken,
    output ir_we, pc_we, pc_sel, rf_we, wb_sel, mem_read_en, mem_write_en
  );

  // Datapath side
  modport slave (
    output opcode, funct3, branch_taken,
    input  ir_we, pc_we, pc_sel, rf_we, wb_sel, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, halting on ECALL or an illegal encoding.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : control bus (instruction fields in, strobes/selects out)
//   halted     : core stopped (sticky until reset)
//   illegal    : halt was caused by an illegal encoding
//   state      : current FSM state, for debug
//   instret    : retired-instruction count (wraps)
// Strobes are Moore decodes of the state register and latched instruction
// class, so they drop in the same instant rst_b falls. pc_sel during a branch
// EXEC follows branch_taken combinationally.
module core_sequencer #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  core_sequencer_if.master bus,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [31:0]      instret
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RET_W = 32;
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_JAL    = 3'd1,
    CL_JALR   = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5
  } class_e;

  state_e             state_q, state_d;
  class_e             cls_q, cls_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic [RET_W-1:0]   instret_q, instret_d;

  class_e             dec_cls;
  logic               dec_ok;
  logic               dec_ecall;

  logic               ir_we_c, pc_we_c, rf_we_c, rd_en_c, wr_en_c;
  logic [1:0]         pc_sel_c, wb_sel_c;

  // Instruction classification from the IR fields
  always_comb begin
    dec_cls   = CL_ALU;
    dec_ok    = 1'b0;
    dec_ecall = 1'b0;
    case (bus.opcode)
      7'h33, 7'h13, 7'h37, 7'h17: dec_ok = 1'b1;
      7'h6F: begin
        dec_cls = CL_JAL;
        dec_ok  = 1'b1;
      end
      7'h67: begin
        dec_cls = CL_JALR;
        dec_ok  = 1'b1;
      end
      7'h03: begin
        dec_cls = CL_LOAD;
        dec_ok  = bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        dec_cls = CL_STORE;
        dec_ok  = bus.funct3 inside {3'd0, 3'd1, 3'd2};
      end
      7'h63: begin
        dec_cls = CL_BRANCH;
        dec_ok  = !(bus.funct3 inside {3'd2, 3'd3});
      end
      7'h73: dec_ecall = 1'b1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      cls_q     <= CL_ALU;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next state and strobe decode
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    pc_sel_c  = 2'd0;
    rf_we_c   = 1'b0;
    wb_sel_c  = 2'd0;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        ir_we_c = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_ecall) begin
          state_d   = ST_HALT;
          // ECALL retires even though it never touches the PC
          instret_d = instret_q + RET_W'(1);
        end else if (!dec_ok) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CL_BRANCH: begin
            pc_we_c  = 1'b1;
            pc_sel_c = {1'b0, bus.branch_taken};
            state_d  = ST_FETCH;
          end
          CL_LOAD, CL_STORE: begin
            cnt_d   = MEM_LOAD;
            state_d = ST_MEM;
          end
          default: state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        if (cls_q == CL_LOAD) begin
          rd_en_c = 1'b1;
        end else begin
          // Counter still at its load value only on the first MEM cycle
          wr_en_c = (cnt_q == MEM_LOAD);
        end
        if (cnt_q == '0) begin
          if (cls_q == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CL_LOAD: wb_sel_c = 2'd1;
          CL_JAL: begin
            wb_sel_c = 2'd2;
            pc_sel_c = 2'd1;
          end
          CL_JALR: begin
            wb_sel_c = 2'd2;
            pc_sel_c = 2'd2;
          end
          default: ;
        endcase
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase

    if (pc_we_c) begin
      instret_d = instret_q + RET_W'(1);
    end
  end

  assign bus.ir_we        = ir_we_c;
  assign bus.pc_we        = pc_we_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.rf_we        = rf_we_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.mem_read_en  = rd_en_c;
  assign bus.mem_write_en = wr_en_c;

  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer with a per-instruction
// strobe-timeline model plus directed reset/halt scenarios.
module tb_core_sequencer;

  localparam int unsigned W = 3;

  localparam int C_ALU = 0, C_JAL = 1, C_JALR = 2, C_LOAD = 3,
                 C_STORE = 4, C_BR = 5, C_ECALL = 6, C_ILL = 7;

  typedef struct packed {
    logic [7:0]  off;
    logic [7:0]  gap;
    logic [2:0]  st;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        rd;
    logic        wr;
    logic [31:0] instret;
  } rec_t;

  logic        clk;
  logic        rst_b;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  core_sequencer_if bus ();

  core_sequencer #(.MEM_WAIT(W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .bus     (bus.master),
    .halted  (halted),
    .illegal (illegal),
    .state   (state),
    .instret (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  int   model_ret = 0;
  int   last_len = 0;

  // ---------------- reference model: strobe timeline per instruction --------
  function automatic rec_t mk(input int off, input int st);
    rec_t r;
    r = '0;
    r.off     = 8'(off);
    r.st      = 3'(st);
    r.instret = 32'(model_ret);
    return r;
  endfunction

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                       input logic tk, input int cls);
    rec_t r;
    int   len;
    int   ret;
    r = mk(0, 1);
    r.ir_we = 1'b1;
    r.gap   = 8'(last_len);
    exp_q.push_back(r);
    len = 0;
    ret = 0;
    case (cls)
      C_ALU, C_JAL, C_JALR: begin
        r = mk(3, 5);
        r.rf_we  = 1'b1;
        r.pc_we  = 1'b1;
        r.wb_sel = (cls == C_ALU) ? 2'd0 : 2'd2;
        r.pc_sel = (cls == C_ALU) ? 2'd0 : (cls == C_JAL) ? 2'd1 : 2'd2;
        exp_q.push_back(r);
        len = 4;
        ret = 1;
      end
      C_BR: begin
        r = mk(2, 3);
        r.pc_we  = 1'b1;
        r.pc_sel = {1'b0, tk};
        exp_q.push_back(r);
        len = 3;
        ret = 1;
      end
      C_LOAD: begin
        for (int i = 0; i < int'(W); i++) begin
          r = mk(3 + i, 4);
          r.rd = 1'b1;
          exp_q.push_back(r);
        end
        r = mk(3 + int'(W), 5);
        r.rf_we  = 1'b1;
        r.pc_we  = 1'b1;
        r.wb_sel = 2'd1;
        exp_q.push_back(r);
        len = 4 + int'(W);
        ret = 1;
      end
      C_STORE: begin
        r = mk(3, 4);
        r.wr    = 1'b1;
        r.pc_we = (W == 1);
        exp_q.push_back(r);
        if (W > 1) begin
          r = mk(3 + int'(W) - 1, 4);
          r.pc_we = 1'b1;
          exp_q.push_back(r);
        end
        len = 3 + int'(W);
        ret = 1;
      end
      C_ECALL: ret = 1;
      default: ;
    endcase
    bus.opcode       = opc;
    bus.funct3       = f3;
    bus.branch_taken = tk;
    last_len  = len;
    model_ret = model_ret + ret;
  endtask

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check_eq(name, {25'd0, bus.ir_we, bus.pc_we, bus.pc_sel, bus.rf_we,
                    bus.wb_sel == 2'd0, bus.mem_read_en | bus.mem_write_en},
             32'h2);
  endtask

  // Advance to the next FETCH (at least one cycle), bounded
  task automatic wait_fetch();
    int n;
    n = 0;
    @(negedge clk);
    while (state !== 3'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (state !== 3'd1) begin
      checks++;
      errors++;
      $display("FAIL wait_fetch timeout state=%0d", state);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    last_len  = 0;
    model_ret = 0;
  endtask

  // ---------------- monitor / scoreboard ------------------------------------
  int cyc = 0;
  int start_cyc = 0;
  bit have_start = 1'b0;

  always begin
    rec_t a;
    rec_t e;
    int   gap;
    @(negedge clk);
    #1;
    cyc++;
    if (!rst_b) begin
      have_start = 1'b0;
    end else if (bus.ir_we | bus.pc_we | bus.rf_we | bus.mem_read_en | bus.mem_write_en) begin
      gap = 0;
      if (bus.ir_we) begin
        gap = have_start ? (cyc - start_cyc) : 0;
        start_cyc  = cyc;
        have_start = 1'b1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe state=%0d ir=%b pc=%b rf=%b rd=%b wr=%b",
                 state, bus.ir_we, bus.pc_we, bus.rf_we, bus.mem_read_en, bus.mem_write_en);
      end else begin
        e = exp_q.pop_front();
        a = '0;
        a.off     = 8'(cyc - start_cyc);
        a.gap     = (e.gap != 8'd0) ? 8'(gap) : 8'd0;
        a.st      = state;
        a.ir_we   = bus.ir_we;
        a.pc_we   = bus.pc_we;
        a.pc_sel  = bus.pc_sel;
        a.rf_we   = bus.rf_we;
        a.wb_sel  = bus.wb_sel;
        a.rd      = bus.mem_read_en;
        a.wr      = bus.mem_write_en;
        a.instret = instret;
        if (a !== e) begin
          errors++;
          $display("FAIL strobe_rec got off=%0d gap=%0d st=%0d ir=%b pc=%b/%0d rf=%b/%0d rd=%b wr=%b ret=%0d expected off=%0d gap=%0d st=%0d ir=%b pc=%b/%0d rf=%b/%0d rd=%b wr=%b ret=%0d",
                   a.off, a.gap, a.st, a.ir_we, a.pc_we, a.pc_sel, a.rf_we, a.wb_sel, a.rd, a.wr, a.instret,
                   e.off, e.gap, e.st, e.ir_we, e.pc_we, e.pc_sel, e.rf_we, e.wb_sel, e.rd, e.wr, e.instret);
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  logic [6:0] alu_ops [4];
  logic [2:0] ld_f3 [5];
  logic [2:0] br_f3 [6];
  int         trace [6];

  initial begin
    int k;
    alu_ops = '{7'h33, 7'h13, 7'h37, 7'h17};
    ld_f3   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    br_f3   = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    trace   = '{0, 1, 2, 3, 5, 1};

    rst_b = 1'b0;
    bus.opcode = 7'h00;
    bus.funct3 = 3'd0;
    bus.branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    check_quiet("rst_strobes");

    // addi with full state trace
    issue(7'h13, 3'd0, 1'b0, C_ALU);
    rst_b = 1'b1;
    check_eq("trace0", 32'(state), 32'(trace[0]));
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check_eq("trace", 32'(state), 32'(trace[i]));
    end
    check_eq("addi_instret", instret, 32'd1);

    // directed: lw, sw, beq taken/not, jal, jalr
    issue(7'h03, 3'd2, 1'b0, C_LOAD);  wait_fetch();
    issue(7'h23, 3'd2, 1'b0, C_STORE); wait_fetch();
    issue(7'h63, 3'd0, 1'b1, C_BR);    wait_fetch();
    issue(7'h63, 3'd0, 1'b0, C_BR);    wait_fetch();
    issue(7'h6F, 3'd0, 1'b0, C_JAL);   wait_fetch();
    issue(7'h67, 3'd0, 1'b0, C_JALR);  wait_fetch();

    // randomized legal instruction stream
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        C_ALU:   issue(alu_ops[$urandom_range(0, 3)], 3'($urandom), 1'($urandom), C_ALU);
        C_JAL:   issue(7'h6F, 3'($urandom), 1'($urandom), C_JAL);
        C_JALR:  issue(7'h67, 3'($urandom), 1'($urandom), C_JALR);
        C_LOAD:  issue(7'h03, ld_f3[$urandom_range(0, 4)], 1'($urandom), C_LOAD);
        C_STORE: issue(7'h23, 3'($urandom_range(0, 2)), 1'($urandom), C_STORE);
        default: issue(7'h63, br_f3[$urandom_range(0, 5)], 1'($urandom), C_BR);
      endcase
      wait_fetch();
    end

    // ECALL: halts, retires, stays quiet
    issue(7'h73, 3'd0, 1'b0, C_ECALL);
    @(negedge clk);
    check_eq("ecall_decode_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check_eq("ecall_illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 100; i++) begin
      bus.opcode = 7'($urandom);
      bus.funct3 = 3'($urandom);
      bus.branch_taken = 1'($urandom);
      check_eq("ecall_halted", 32'(halted), 32'd1);
      check_eq("ecall_instret", instret, 32'(model_ret));
      check_quiet("ecall_strobes");
      @(negedge clk);
    end
    check_eq("ecall_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset out of HALT, addi then illegal opcode 0x7F
    rst_b = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    check_eq("rst2_halted", 32'(halted), 32'd0);
    check_eq("rst2_instret", instret, 32'd0);
    issue(7'h13, 3'd0, 1'b0, C_ALU);
    rst_b = 1'b1;
    @(negedge clk);
    wait_fetch();
    issue(7'h7F, 3'd0, 1'b0, C_ILL);
    repeat (2) @(negedge clk);
    check_eq("ill7f_halted", 32'(halted), 32'd1);
    check_eq("ill7f_illegal", 32'(illegal), 32'd1);
    check_eq("ill7f_instret", instret, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("ill7f_sticky", 32'(halted), 32'd1);
    check_quiet("ill7f_strobes");
    check_eq("ill7f_queue_empty", 32'(exp_q.size()), 32'd0);

    // load with funct3=3 is illegal
    rst_b = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    check_eq("rst3_illegal", 32'(illegal), 32'd0);
    issue(7'h03, 3'd3, 1'b0, C_ILL);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("illld_halted", 32'(halted), 32'd1);
    check_eq("illld_illegal", 32'(illegal), 32'd1);
    check_eq("illld_instret", instret, 32'd0);

    // reset asserted in the middle of a load MEM phase
    rst_b = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    issue(7'h13, 3'd0, 1'b0, C_ALU);
    rst_b = 1'b1;
    @(negedge clk);
    wait_fetch();
    issue(7'h03, 3'd2, 1'b0, C_LOAD);
    k = 0;
    while (state !== 3'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("midrst_reached_mem", 32'(state), 32'd4);
    check_eq("midrst_pre_instret", instret, 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    check_eq("midrst_state", 32'(state), 32'd0);
    check_eq("midrst_instret", instret, 32'd0);
    check_eq("midrst_halted", 32'(halted), 32'd0);
    check_eq("midrst_illegal", 32'(illegal), 32'd0);
    check_quiet("midrst_strobes");
    flush();
    repeat (3) @(negedge clk);
    check_quiet("midrst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the write strobes and mux selects for the PC, the instruction register, the register file and the data-memory port. It replaces the free-running per-clock advance of the core. It detects ECALL and illegal encodings and halts.

## Interface
- MEM_WAIT, 1: number of cycles the data memory needs per access. Legal range 1..15.

- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- opcode  in  7  IR[6:0]; stable from DECODE onward
- funct3  in  3  IR[14:12]
- branch_taken  in  1  ALU compare result; valid in EXEC
- ir_we  out  1  latch instruction-memory word into IR
- pc_we  out  1  update PC
- pc_sel  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = pc+4
- mem_read_en  out  1  data-memory read
- mem_write_en  out  1  data-memory write
- halted  out  1  core stopped
- illegal  out  1  halt was caused by an illegal encoding
- state  out  3  current state, for debug
- instret  out  32  retired-instruction count

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: all strobes 0; next state is FETCH unconditionally.
- FETCH: ir_we=1; next state is DECODE.
- DECODE: latch opcode/funct3 internally, then classify:
  - 0x33, 0x13, 0x37, 0x17, 0x6F, 0x67 -> EXEC.
  - 0x03 with funct3 in {0,1,2,4,5} -> EXEC.
  - 0x23 with funct3 in {0,1,2} -> EXEC.
  - 0x63 with funct3 not in {2,3} -> EXEC.
  - 0x73 -> HALT (ECALL).
  - Anything else -> HALT with illegal=1.
- EXEC, by class:
  - Branch: pc_we=1 and pc_sel={1'b0,branch_taken} (combinational from branch_taken); next state FETCH.
  - Load/store: next state MEM.
  - All others: next state WB.
- MEM:
  - A 4-bit counter is loaded with MEM_WAIT-1 on entry and stays in MEM until it reaches 0.
  - Load: mem_read_en=1 for every MEM cycle; next state WB.
  - Store: mem_write_en=1 on the first MEM cycle only. On the last MEM cycle pc_we=1, pc_sel=0. Next state FETCH.
- WB: rf_we=1, pc_we=1; next state FETCH.
  - ALU/LUI/AUIPC: wb_sel=0, pc_sel=0.
  - Load: wb_sel=1, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2.
- HALT: all strobes 0, halted=1, sticky until reset. The opcode/funct3 inputs are ignored.
- When a strobe is inactive, its select outputs are 0.
- instret:
  - Increments on every cycle with pc_we=1, and on the DECODE->HALT transition for ECALL.
  - Does not increment for an illegal encoding.
  - Wraps from 0xFFFFFFFF to 0.
- Every strobe is active for exactly one cycle per instruction, except mem_read_en, which is active for MEM_WAIT cycles.

## Timing
- Reset, asynchronous and immediate: state=IDLE, MEM counter=0, instret=0, halted=0, illegal=0, all strobes and selects 0. This also applies mid-instruction; no partial write completes after rst_b falls.
- First FETCH is the second rising edge after rst_b deasserts.
- Strobes are Moore outputs decoded from state and the latched opcode. The only exception is pc_sel in a branch EXEC.
- Cycles per instruction, FETCH through last state inclusive:
  - ALU/LUI/AUIPC/JAL/JALR: 4
  - Branch: 3
  - Load: 4+MEM_WAIT
  - Store: 3+MEM_WAIT
  - ECALL/illegal: halted rises 2 cycles after FETCH (FETCH, DECODE, then HALT).
- The IR is written at the end of FETCH. opcode/funct3 must be valid in DECODE and are held by the IR thereafter.

## Test plan
- Reset, then addi (opcode 0x13):
  - state sequence 0,1,2,3,5,1.
  - In WB: rf_we=pc_we=1 for one cycle, wb_sel=0, pc_sel=0.
  - instret=1 after WB.
- lw (0x03, funct3=2), MEM_WAIT=3:
  - mem_read_en high exactly 3 cycles, then WB with wb_sel=1.
  - Instruction takes 7 cycles; mem_write_en never asserts.
- sw (0x23, funct3=2), MEM_WAIT=3:
  - mem_write_en high exactly 1 cycle (first MEM cycle).
  - pc_we on the 3rd MEM cycle; rf_we never asserts; 6 cycles.
- beq (0x63), branch_taken=1 then 0:
  - EXEC pc_we=1 with pc_sel=1, then pc_sel=0; no rf_we; 3 cycles each.
- JAL then JALR:
  - WB wb_sel=2, rf_we=1, pc_sel=1 and 2 respectively.
- Halt and reset:
  - ECALL (0x73): halted=1 from the cycle after DECODE, held for 100 cycles with zero strobes; instret +1.
  - Opcode 0x7F or load funct3=3: halted=1, illegal=1, instret unchanged.
  - rst_b low during load MEM: all outputs 0 immediately, state=0, instret=0.
